// File: rtl/common_gnss_types_pkg.sv
// common_gnss_types_pkg: shared GNSS types, including acquisition scheduler state/result records.
package common_gnss_types_pkg;
    localparam int WORD_W = 32;
    localparam int L1CA_CODE_MOD = 4092;
    typedef logic [WORD_W-1:0] word_t;
    typedef logic [4:0] sv_t;
    typedef enum logic [2:0] {IDLE, SELECT, DWELL, DRAIN, EVAL, REPORT, DONE, ABORT} acq_state_t;
    typedef struct packed {
        sv_t         sv;
        logic        detect;
        logic [3:0]  hits;
        word_t       acc;
        logic [11:0] code;
        logic [4:0]  dop;
        logic        timeout;
    } acq_result_t;
    // {found, index} of the lowest set bit
    function automatic logic [5:0] lowest_set(input logic [31:0] m);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--)
            if (m[i]) lowest_set = {1'b1, 5'(i)};
    endfunction
endpackage

// File: rtl/l1ca_code_dist.sv
// l1ca_code_dist: registered wrap-around code-index distance test against CODE_TOL.
module l1ca_code_dist
    import common_gnss_types_pkg::*;
#(
    parameter int CODE_MOD = L1CA_CODE_MOD,
    parameter int CODE_TOL = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [11:0] a,
    input  logic [11:0] b,
    output logic        near
);
    logic [12:0] diff;
    logic [12:0] wrap;
    assign diff = (a >= b) ? 13'(a - b) : 13'(b - a);
    assign wrap = 13'(CODE_MOD) - diff;
    always_ff @(posedge clk or posedge rst)
        if (rst) near <= 1'b0;
        else if (en) near <= diff <= 13'(CODE_TOL) || (diff <= 13'(CODE_MOD) && wrap <= 13'(CODE_TOL));
endmodule

// File: rtl/l1ca_acq_sched.sv
// l1ca_acq_sched: sweeps enabled PRNs through one search engine with an M-of-N dwell consistency test.
// Define L1CA_ACQ_TIMEOUT_EN to bound engine drain and abort waits by TIMEOUT_CYC.
module l1ca_acq_sched
    import common_gnss_types_pkg::*;
#(
    parameter int ACC_W = 32,
    parameter int DOP_W = 5,
    parameter int DWELL_SAMPLES = 19200,
    parameter int N_DWELL = 3,
    parameter int M_HITS = 2,
    parameter int CODE_MOD = L1CA_CODE_MOD,
    parameter int CODE_TOL = 2
`ifdef L1CA_ACQ_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1000000
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             abort,
    input  logic [31:0]      sv_mask,
    input  logic [ACC_W-1:0] thresh,
    output logic             eng_start,
    output logic [4:0]       eng_sv,
    input  logic             eng_busy,
    input  logic [ACC_W-1:0] eng_acc,
    input  logic [11:0]      eng_code,
    input  logic [DOP_W-1:0] eng_dop,
    output logic             res_valid,
    output logic [4:0]       res_sv,
    output logic             res_detect,
    output logic [3:0]       res_hits,
    output logic [ACC_W-1:0] res_acc,
    output logic [11:0]      res_code,
    output logic [DOP_W-1:0] res_dop,
    output logic             res_timeout,
    output logic             busy,
    output logic             done
);
    acq_state_t       state;
    acq_state_t       state_nx;
    logic [31:0]      cnt;
    logic [31:0]      mask_q;
    logic [ACC_W-1:0] thr_q;
    logic [3:0]       dwell_q;
    logic [3:0]       hits_q;
    logic [11:0]      ref_code;
    logic [DOP_W-1:0] ref_dop;
    logic [ACC_W-1:0] best_acc;
    logic [11:0]      best_code;
    logic [DOP_W-1:0] best_dop;
    logic [ACC_W-1:0] cap_acc;
    logic [11:0]      cap_code;
    logic [DOP_W-1:0] cap_dop;
    acq_result_t      res_q;
    logic [5:0]       pick;
    logic             cap_en;
    logic             tmo;
    logic             near;
    logic             hit;
    logic             counted;
    logic             better;
    logic             detect;
    logic             giveup;
    logic [3:0]       hits_nx;
    logic [3:0]       dwell_nx;
    logic [ACC_W-1:0] best_acc_nx;
    logic [11:0]      best_code_nx;
    logic [DOP_W-1:0] best_dop_nx;

    assign pick = lowest_set(mask_q);
    assign cap_en = state == DRAIN && cnt >= 32'd2 && !eng_busy;
`ifdef L1CA_ACQ_TIMEOUT_EN
    assign tmo = (state == DRAIN || state == ABORT) && cnt >= 32'(TIMEOUT_CYC);
`else
    assign tmo = 1'b0;
`endif

    // the distance flag is registered on the capture edge so it is ready during EVAL
    l1ca_code_dist #(.CODE_MOD(CODE_MOD), .CODE_TOL(CODE_TOL)) u_dist (
        .clk (clk),
        .rst (rst),
        .en  (cap_en),
        .a   (eng_code),
        .b   (ref_code),
        .near(near)
    );

    assign hit = cap_acc >= thr_q;
    assign counted = hit && (hits_q == '0 || (cap_dop == ref_dop && near));
    assign better = counted && (hits_q == '0 || cap_acc > best_acc);
    assign hits_nx = hits_q + 4'(counted);
    assign dwell_nx = dwell_q + 4'd1;
    assign detect = hits_nx == 4'(M_HITS);
    assign giveup = {1'b0, hits_nx} + 5'(N_DWELL) - {1'b0, dwell_nx} < 5'(M_HITS);
    assign best_acc_nx = better ? cap_acc : best_acc;
    assign best_code_nx = better ? cap_code : best_code;
    assign best_dop_nx = better ? cap_dop : best_dop;

    assign res_sv = res_q.sv;
    assign res_detect = res_q.detect;
    assign res_hits = res_q.hits;
    assign res_acc = ACC_W'(res_q.acc);
    assign res_code = res_q.code;
    assign res_dop = DOP_W'(res_q.dop);
    assign res_timeout = res_q.timeout;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        busy = state != IDLE && state != DONE;
        done = state == DONE;
        res_valid = state == REPORT;
        case (state)
            IDLE:    if (go) state_nx = (sv_mask == '0) ? DONE : SELECT;
            SELECT:  state_nx = pick[5] ? DWELL : DONE;
            DWELL:   if (cnt == 32'(DWELL_SAMPLES)) state_nx = DRAIN;
            DRAIN:   if (cap_en) state_nx = EVAL; else if (tmo) state_nx = REPORT;
            EVAL:    state_nx = (detect || giveup) ? REPORT : DWELL;
            REPORT:  state_nx = SELECT;
            DONE:    state_nx = IDLE;
            ABORT:   if (!eng_busy || tmo) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
        if (abort && state != IDLE && state != DONE && state != ABORT) state_nx = ABORT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            eng_start <= 1'b0;
            eng_sv <= '0;
            mask_q <= '0;
            thr_q <= '0;
            dwell_q <= '0;
            hits_q <= '0;
            ref_code <= '0;
            ref_dop <= '0;
            best_acc <= '0;
            best_code <= '0;
            best_dop <= '0;
            cap_acc <= '0;
            cap_code <= '0;
            cap_dop <= '0;
            res_q <= '0;
        end else begin
            // per-state cycle counter, saturating so a long drain never wraps
            cnt <= (state_nx != state) ? '0 : cnt + 32'(cnt != '1);
            eng_start <= state == DWELL && state_nx == DWELL;
            if (state == IDLE && go) begin
                mask_q <= sv_mask;
                thr_q <= thresh;
            end
            if (state == SELECT) begin
                if (pick[5]) eng_sv <= pick[4:0];
                dwell_q <= '0;
                hits_q <= '0;
                ref_code <= '0;
                ref_dop <= '0;
                best_acc <= '0;
                best_code <= '0;
                best_dop <= '0;
            end
            if (cap_en) begin
                cap_acc <= eng_acc;
                cap_code <= eng_code;
                cap_dop <= eng_dop;
            end
            if (state == EVAL) begin
                dwell_q <= dwell_nx;
                hits_q <= hits_nx;
                if (counted && hits_q == '0) begin
                    ref_code <= cap_code;
                    ref_dop <= cap_dop;
                end
                best_acc <= best_acc_nx;
                best_code <= best_code_nx;
                best_dop <= best_dop_nx;
                if (detect || giveup) begin
                    res_q.sv <= eng_sv;
                    res_q.detect <= detect;
                    res_q.hits <= hits_nx;
                    res_q.acc <= word_t'(detect ? best_acc_nx : cap_acc);
                    res_q.code <= detect ? best_code_nx : cap_code;
                    res_q.dop <= 5'(detect ? best_dop_nx : cap_dop);
                    res_q.timeout <= 1'b0;
                end
            end
            if (state == DRAIN && !cap_en && tmo) begin
                res_q <= '0;
                res_q.sv <= eng_sv;
                res_q.timeout <= 1'b1;
            end
            if (state == REPORT) mask_q[eng_sv] <= 1'b0;
        end
    end
endmodule

// File: tb/tb_l1ca_acq_sched.sv
// tb_l1ca_acq_sched: scoreboard bench for l1ca_acq_sched with a scripted search-engine model.
// Timeout scenario runs only when L1CA_ACQ_TIMEOUT_EN is defined.
module tb_l1ca_acq_sched;
    localparam int DS = 8;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] sv_mask = '0;
    logic [31:0] thresh = '0;
    logic        eng_start;
    logic [4:0]  eng_sv;
    logic        eng_busy = 1'b0;
    logic [31:0] eng_acc = '0;
    logic [11:0] eng_code = '0;
    logic [4:0]  eng_dop = '0;
    logic        res_valid;
    logic [4:0]  res_sv;
    logic        res_detect;
    logic [3:0]  res_hits;
    logic [31:0] res_acc;
    logic [11:0] res_code;
    logic [4:0]  res_dop;
    logic        res_timeout;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  sv;
        logic        det;
        logic [3:0]  hits;
        logic [31:0] acc;
        logic [11:0] code;
        logic [4:0]  dop;
        logic        tmo;
        bit          data;
    } exp_t;
    typedef struct {
        logic [31:0] acc;
        logic [11:0] code;
        logic [4:0]  dop;
    } dw_t;
    exp_t exp_q[$];
    dw_t  eng_q[$];
    exp_t mon_e;
    logic prev_start = 1'b0;
    int   tail = 0;
    bit   hang = 1'b0;
    int   n_dwell = 0;

    l1ca_acq_sched #(
        .DWELL_SAMPLES(DS)
`ifdef L1CA_ACQ_TIMEOUT_EN
        , .TIMEOUT_CYC(100)
`endif
    ) dut (
        .clk(clk), .rst(rst), .go(go), .abort(abort), .sv_mask(sv_mask), .thresh(thresh),
        .eng_start(eng_start), .eng_sv(eng_sv), .eng_busy(eng_busy), .eng_acc(eng_acc),
        .eng_code(eng_code), .eng_dop(eng_dop), .res_valid(res_valid), .res_sv(res_sv),
        .res_detect(res_detect), .res_hits(res_hits), .res_acc(res_acc), .res_code(res_code),
        .res_dop(res_dop), .res_timeout(res_timeout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // engine model: loads the next scripted result at each dwell start, stays busy a few cycles after start drops
    always @(posedge clk) begin
        prev_start <= eng_start;
        if (eng_start && !prev_start) begin
            n_dwell <= n_dwell + 1;
            if (eng_q.size() != 0) begin
                eng_acc <= eng_q[0].acc;
                eng_code <= eng_q[0].code;
                eng_dop <= eng_q[0].dop;
                eng_q.delete(0);
            end
        end
        tail <= eng_start ? 4 : (tail > 0 ? tail - 1 : 0);
        eng_busy <= eng_start || tail > 0 || hang;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (res_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL res_unexpected: got res_valid for sv %0d expected none", res_sv);
            end else begin
                mon_e = exp_q.pop_front();
                chk("res_sv", 64'(res_sv), 64'(mon_e.sv));
                chk("res_detect", 64'(res_detect), 64'(mon_e.det));
                chk("res_hits", 64'(res_hits), 64'(mon_e.hits));
                chk("res_timeout", 64'(res_timeout), 64'(mon_e.tmo));
                if (mon_e.data) begin
                    chk("res_acc", 64'(res_acc), 64'(mon_e.acc));
                    chk("res_code", 64'(res_code), 64'(mon_e.code));
                    chk("res_dop", 64'(res_dop), 64'(mon_e.dop));
                end
            end
        end
    end

    task automatic dw(input logic [31:0] a, input logic [11:0] c, input logic [4:0] d);
        dw_t r;
        r.acc = a;
        r.code = c;
        r.dop = d;
        eng_q.push_back(r);
    endtask

    task automatic expect_res(input logic [4:0] sv, input logic det, input logic [3:0] h, input logic [31:0] a,
                              input logic [11:0] c, input logic [4:0] d, input logic t, input bit data);
        exp_t e;
        e.sv = sv;
        e.det = det;
        e.hits = h;
        e.acc = a;
        e.code = c;
        e.dop = d;
        e.tmo = t;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic pulse_go(input logic [31:0] m, input logic [31:0] t);
        @(negedge clk);
        sv_mask = m;
        thresh = t;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        chk("busy_after_go", 64'(busy), 64'(m != 0));
    endtask

    task automatic wait_done(input string name, input int max);
        int n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_done"}, 64'(done), 64'd1);
        chk({name, "_busy_low_at_done"}, 64'(busy), 64'd0);
    endtask

    task automatic settle(input string name);
        repeat (12) @(negedge clk);
        chk({name, "_pending"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) @(negedge clk);
        chk("rst_eng_start", 64'(eng_start), 64'd0);
        chk("rst_eng_sv", 64'(eng_sv), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_acc", 64'(res_acc), 64'd0);
        rst = 1'b0;

        // single SV detected after two consistent hits
        eng_q.delete();
        dw(500, 100, 7); dw(510, 100, 7); dw(0, 100, 7);
        expect_res(11, 1, 2, 510, 100, 7, 0, 1);
        d0 = n_dwell;
        pulse_go(32'h0000_0800, 400);
        wait_done("t1", 400);
        chk("t1_dwells", 64'(n_dwell - d0), 64'd2);
        chk("t1_eng_sv", 64'(eng_sv), 64'd11);
        settle("t1");

        // two SVs, all misses: early give-up after two dwells each
        eng_q.delete();
        repeat (4) dw(10, 50, 3);
        expect_res(0, 0, 0, 10, 50, 3, 0, 1);
        expect_res(2, 0, 0, 10, 50, 3, 0, 1);
        d0 = n_dwell;
        pulse_go(32'h0000_0005, 400);
        wait_done("t2", 600);
        chk("t2_dwells", 64'(n_dwell - d0), 64'd4);
        settle("t2");

        // code wrap-around counts as consistent; a 3-chip offset does not
        eng_q.delete();
        dw(600, 4091, 9); dw(700, 1, 9);
        dw(600, 100, 4); dw(650, 103, 4); dw(0, 103, 4);
        expect_res(0, 1, 2, 700, 1, 9, 0, 1);
        expect_res(1, 0, 1, 0, 103, 4, 0, 1);
        d0 = n_dwell;
        pulse_go(32'h0000_0003, 400);
        wait_done("t3", 800);
        chk("t3_dwells", 64'(n_dwell - d0), 64'd5);
        settle("t3");

        // empty mask finishes at once
        d0 = n_dwell;
        pulse_go(32'h0, 400);
        wait_done("t4", 10);
        chk("t4_dwells", 64'(n_dwell - d0), 64'd0);
        settle("t4");

        // abort during the second SV's dwell
        eng_q.delete();
        repeat (4) dw(500, 10, 1);
        expect_res(0, 1, 2, 500, 10, 1, 0, 1);
        pulse_go(32'h0000_0003, 400);
        n = 0;
        while (!(eng_sv == 5'd1 && eng_start) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_sv1", 64'(eng_sv == 5'd1 && eng_start), 64'd1);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_start_low", 64'(eng_start), 64'd0);
        wait_done("t5", 100);
        chk("t5_eng_idle_at_done", 64'(eng_busy), 64'd0);
        settle("t5");

        // reset while draining, then restart from the lowest enabled PRN
        eng_q.delete();
        repeat (2) dw(500, 20, 2);
        pulse_go(32'h0000_0006, 400);
        n = 0;
        while (!eng_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        while (eng_start && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t6_in_drain", 64'(eng_start == 1'b0 && busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_eng_sv", 64'(eng_sv), 64'd0);
        chk("t6_rst_res_acc", 64'(res_acc), 64'd0);
        chk("t6_rst_res_hits", 64'(res_hits), 64'd0);
        chk("t6_rst_res_detect", 64'(res_detect), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        eng_q.delete();
        repeat (2) dw(500, 20, 2);
        repeat (2) dw(10, 30, 1);
        expect_res(1, 1, 2, 500, 20, 2, 0, 1);
        expect_res(2, 0, 0, 10, 30, 1, 0, 1);
        d0 = n_dwell;
        pulse_go(32'h0000_0006, 400);
        wait_done("t6", 600);
        chk("t6_dwells", 64'(n_dwell - d0), 64'd4);
        settle("t6");

`ifdef L1CA_ACQ_TIMEOUT_EN
        // engine never goes idle: each SV times out and the sweep moves on
        eng_q.delete();
        hang = 1'b1;
        expect_res(0, 0, 0, 0, 0, 0, 1, 0);
        expect_res(1, 0, 0, 0, 0, 0, 1, 0);
        pulse_go(32'h0000_0003, 400);
        wait_done("t7", 1000);
        hang = 1'b0;
        settle("t7");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of run expected summary before time limit");
        $fatal(1);
    end
endmodule
